// File: rtl/xorexec_pkg.sv
// Shared types and helpers for the xorexec packet arbiter.
// Holds the arbiter FSM encoding, the default byte width and the tag-width helper.
package xorexec_pkg;

  typedef enum logic [1:0] {IDLE, HDR, BODY} arb_state_t;

  localparam int DWIDTH_DEF = 8;

  // Index width for n entries; never below one bit so single-entry users still get a port.
  function automatic int tag_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/xorexec_tag_fifo.sv
// Requester-ID tag FIFO: DEPTH entries (power of 2, >= 2), head visible combinationally.
// Zero-latency head; a push while full is accepted only when paired with a pop.
module xorexec_tag_fifo
  import xorexec_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  localparam int AW = tag_w(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/xorexec_arb.sv
// Packet-level round-robin arbiter sharing one xorexec engine among NREQ byte FIFOs.
// One-cycle grant, then zero-latency pass-through; results steered back by a tag FIFO.
module xorexec_arb
  import xorexec_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int DWIDTH   = DWIDTH_DEF,
  parameter int TAGDEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_rdy,
  input  logic [NREQ*DWIDTH-1:0]   req_data,
  output logic [NREQ-1:0]          req_pop,
  output logic                     eng_rdy,
  output logic [DWIDTH-1:0]        eng_data,
  input  logic                     eng_pop,
  input  logic                     eng_push,
  input  logic [DWIDTH-1:0]        eng_odata,
  output logic                     eng_not_full,
  input  logic [NREQ-1:0]          res_not_full,
  output logic [NREQ-1:0]          res_push,
  output logic [DWIDTH-1:0]        res_data,
  output logic [$clog2(NREQ)-1:0]  gnt_id,
  output logic                     busy,
  output logic                     err
);

  localparam int TW = tag_w(NREQ);

  arb_state_t        state;
  arb_state_t        state_nxt;
  logic [TW-1:0]     last;
  logic [DWIDTH-1:0] remaining;
  logic [DWIDTH-1:0] gnt_byte;
  logic [TW-1:0]     head;
  logic              tag_full;
  logic              tag_empty;
  logic              grant;
  logic              pop_ok;
  logic              push_ok;
  logic              tag_push;

  // First ready requester strictly after lst, wrapping; lst itself comes last.
  function automatic logic [TW-1:0] rr_pick(input logic [NREQ-1:0] rdy,
                                            input logic [TW-1:0]   lst);
    logic [TW-1:0] pick;
    logic          found;
    int            idx;
    pick  = lst;
    found = 1'b0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = (int'(lst) + i) % NREQ;
      if (!found && rdy[idx]) begin
        pick  = TW'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  assign gnt_byte = req_data[int'(gnt_id)*DWIDTH +: DWIDTH];
  assign busy     = (state != IDLE);
  assign res_data = eng_odata;

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    eng_rdy   = 1'b0;
    eng_data  = req_data[DWIDTH-1:0];
    pop_ok    = 1'b0;
    tag_push  = 1'b0;
    case (state)
      IDLE: begin
        if ((|req_rdy) && !tag_full) begin
          grant     = 1'b1;
          state_nxt = HDR;
        end
      end
      HDR: begin
        eng_rdy  = req_rdy[gnt_id];
        eng_data = gnt_byte;
        pop_ok   = eng_pop && eng_rdy;
        if (pop_ok) begin
          tag_push  = 1'b1;
          state_nxt = (gnt_byte == '0) ? IDLE : BODY;
        end
      end
      BODY: begin
        eng_rdy  = req_rdy[gnt_id];
        eng_data = gnt_byte;
        pop_ok   = eng_pop && eng_rdy;
        if (pop_ok && remaining == DWIDTH'(1)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Result side is steered purely by the oldest outstanding tag.
  assign eng_not_full = !tag_empty && res_not_full[head];
  assign push_ok      = eng_push && eng_not_full;

  always_comb begin
    req_pop  = '0;
    res_push = '0;
    if (pop_ok && !rst)  req_pop[gnt_id] = 1'b1;
    if (push_ok && !rst) res_push[head]  = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      gnt_id    <= '0;
      last      <= TW'(NREQ-1);
      remaining <= '0;
      err       <= 1'b0;
    end else begin
      state <= state_nxt;
      if (grant) gnt_id <= rr_pick(req_rdy, last);
      if (tag_push) begin
        remaining <= gnt_byte;
        last      <= gnt_id;
      end else if (state == BODY && pop_ok) begin
        remaining <= remaining - 1'b1;
      end
      err <= err | (eng_pop && !eng_rdy) | (eng_push && !eng_not_full);
    end
  end

  xorexec_tag_fifo #(
    .DEPTH (TAGDEPTH),
    .W     (TW)
  ) u_tag_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tag_push),
    .din   (gnt_id),
    .pop   (push_ok),
    .full  (tag_full),
    .empty (tag_empty),
    .head  (head)
  );

endmodule

// File: tb/tb_xorexec_arb.sv
// Directed bench for xorexec_arb; the bench plays both the requester FIFOs and the engine.
module tb_xorexec_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_rdy;
  logic [7:0]  rd [4];
  logic [31:0] req_data;
  logic [3:0]  req_pop;
  logic        eng_rdy;
  logic [7:0]  eng_data;
  logic        eng_pop;
  logic        eng_push;
  logic [7:0]  eng_odata;
  logic        eng_not_full;
  logic [3:0]  res_not_full;
  logic [3:0]  res_push;
  logic [7:0]  res_data;
  logic [1:0]  gnt_id;
  logic        busy;
  logic        err;

  int total  = 0;
  int passes = 0;
  int pops;

  always #5 clk = ~clk;

  assign req_data = {rd[3], rd[2], rd[1], rd[0]};

  xorexec_arb #(
    .NREQ     (4),
    .DWIDTH   (8),
    .TAGDEPTH (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_rdy      (req_rdy),
    .req_data     (req_data),
    .req_pop      (req_pop),
    .eng_rdy      (eng_rdy),
    .eng_data     (eng_data),
    .eng_pop      (eng_pop),
    .eng_push     (eng_push),
    .eng_odata    (eng_odata),
    .eng_not_full (eng_not_full),
    .res_not_full (res_not_full),
    .res_push     (res_push),
    .res_data     (res_data),
    .gnt_id       (gnt_id),
    .busy         (busy),
    .err          (err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst          = 1'b1;
    req_rdy      = '0;
    for (int i = 0; i < 4; i++) rd[i] = '0;
    eng_pop      = 1'b0;
    eng_push     = 1'b0;
    eng_odata    = '0;
    res_not_full = 4'hF;
    tick;
    tick;

    // Reset values
    chk("rst_busy",     busy,         0);
    chk("rst_err",      err,          0);
    chk("rst_gnt",      gnt_id,       0);
    chk("rst_eng_rdy",  eng_rdy,      0);
    chk("rst_eng_data", eng_data,     0);
    chk("rst_not_full", eng_not_full, 0);
    chk("rst_req_pop",  req_pop,      0);
    chk("rst_res_push", res_push,     0);
    rst = 1'b0;

    // Single packet from requester 2: 03 11 22 33
    req_rdy = 4'b0100;
    rd[2]   = 8'h03;
    #1;
    chk("t1_idle_eng_rdy", eng_rdy, 0);
    tick;
    chk("t1_gnt",      gnt_id,   2);
    chk("t1_busy",     busy,     1);
    chk("t1_eng_rdy",  eng_rdy,  1);
    chk("t1_eng_data", eng_data, 8'h03);
    pops = 0;
    for (int k = 0; k < 4; k++) begin
      if (k != 0) rd[2] = 8'h11 * k[7:0];
      eng_pop = 1'b1;
      #1;
      chk("t1_req_pop", req_pop, 4'b0100);
      if (req_pop[2]) pops++;
      tick;
    end
    eng_pop = 1'b0;
    req_rdy = '0;
    #1;
    chk("t1_pop_count", pops,         4);
    chk("t1_done_busy", busy,         0);
    chk("t1_tag_ready", eng_not_full, 1);
    eng_push  = 1'b1;
    eng_odata = 8'h00;
    #1;
    chk("t1_res_push", res_push, 4'b0100);
    chk("t1_res_data", res_data, 8'h00);
    tick;
    eng_push = 1'b0;
    #1;
    chk("t1_tag_empty", eng_not_full, 0);
    chk("t1_err",       err,          0);

    // Round robin with every requester ready
    rst = 1'b1;
    tick;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) rd[i] = 8'h01;
    req_rdy = 4'hF;
    for (int k = 0; k < 5; k++) begin
      int e;
      e        = k % 4;
      eng_pop  = 1'b0;
      eng_push = 1'b0;
      #1;
      chk("t2_idle_gap", busy, 0);
      tick;
      chk("t2_gnt", gnt_id, e);
      eng_pop = 1'b1;
      #1;
      chk("t2_hdr_pop", req_pop, 32'd1 << e);
      tick;
      eng_push = 1'b1;
      #1;
      chk("t2_body_pop", req_pop,  32'd1 << e);
      chk("t2_res_push", res_push, 32'd1 << e);
      tick;
    end
    eng_pop  = 1'b0;
    eng_push = 1'b0;
    req_rdy  = '0;
    #1;
    chk("t2_err", err, 0);

    // Zero-length packet from requester 1
    req_rdy = 4'b0010;
    rd[1]   = 8'h00;
    tick;
    chk("t3_gnt", gnt_id, 1);
    eng_pop = 1'b1;
    #1;
    chk("t3_req_pop", req_pop, 4'b0010);
    tick;
    eng_pop = 1'b0;
    req_rdy = '0;
    #1;
    chk("t3_back_idle", busy,         0);
    chk("t3_tag_ready", eng_not_full, 1);
    eng_push = 1'b1;
    #1;
    chk("t3_res_push", res_push, 4'b0010);
    tick;
    eng_push = 1'b0;

    // Tag FIFO full blocks the fifth grant
    rd[0]   = 8'h00;
    req_rdy = 4'b0001;
    for (int k = 0; k < 4; k++) begin
      tick;
      eng_pop = 1'b1;
      #1;
      chk("t4_fill_pop", req_pop, 4'b0001);
      tick;
      eng_pop = 1'b0;
    end
    tick;
    tick;
    chk("t4_blocked", busy, 0);
    eng_push = 1'b1;
    #1;
    chk("t4_res_push", res_push, 4'b0001);
    tick;
    eng_push = 1'b0;
    #1;
    chk("t4_still_idle", busy, 0);
    tick;
    chk("t4_resumed", busy,   1);
    chk("t4_gnt",     gnt_id, 0);
    eng_pop = 1'b1;
    tick;
    eng_pop = 1'b0;
    req_rdy = '0;
    for (int k = 0; k < 4; k++) begin
      eng_push = 1'b1;
      #1;
      chk("t4_drain", res_push, 4'b0001);
      tick;
    end
    eng_push = 1'b0;
    #1;
    chk("t4_empty", eng_not_full, 0);
    chk("t4_err",   err,          0);

    // Result FIFO full: forced push is an error and leaves the tag in place
    req_rdy = 4'b1000;
    rd[3]   = 8'h00;
    tick;
    chk("t5_gnt", gnt_id, 3);
    eng_pop = 1'b1;
    tick;
    eng_pop      = 1'b0;
    req_rdy      = '0;
    res_not_full = 4'b0111;
    #1;
    chk("t5_not_full", eng_not_full, 0);
    eng_push = 1'b1;
    #1;
    chk("t5_dropped", res_push, 0);
    tick;
    eng_push     = 1'b0;
    res_not_full = 4'hF;
    #1;
    chk("t5_err",       err,          1);
    chk("t5_tag_kept",  eng_not_full, 1);
    eng_push = 1'b1;
    #1;
    chk("t5_head_same", res_push, 4'b1000);
    tick;
    eng_push = 1'b0;

    // Reset in BODY with 5 bytes left
    req_rdy = 4'b0010;
    rd[1]   = 8'h06;
    tick;
    chk("t6_gnt", gnt_id, 1);
    eng_pop = 1'b1;
    tick;
    tick;
    chk("t6_in_body", busy, 1);
    rst      = 1'b1;
    eng_push = 1'b1;
    #1;
    chk("t6_rst_req_pop",  req_pop,  0);
    chk("t6_rst_res_push", res_push, 0);
    tick;
    rst      = 1'b0;
    eng_pop  = 1'b0;
    eng_push = 1'b0;
    #1;
    chk("t6_busy",      busy,         0);
    chk("t6_err_clear", err,          0);
    chk("t6_tag_empty", eng_not_full, 0);
    req_rdy = 4'hF;
    tick;
    chk("t6_gnt_after", gnt_id, 0);
    chk("t6_busy_after", busy,  1);
    req_rdy = '0;

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
